// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and timing defaults for the button pipeline
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HELD
    } state_t;

    localparam int LONG_DEFAULT = 100_000_000;
    localparam int GAP_DEFAULT  = 25_000_000;

    // The shared timer must cover whichever of the two windows is longer
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: clearable up-counter with a terminal-value match flag
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         done
);

    // Clear has priority so a state change always restarts the window at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign done = count == term;

endmodule

// File: rtl/press_classifier.sv
// press_classifier: classifies debounced presses into short, long and double events
module press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES = LONG_DEFAULT,
    parameter int GAP_CYCLES  = GAP_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db_level,
    input  logic       press_edge,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       held,
    output logic [7:0] event_count
);

    localparam int W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES));
    localparam logic [W-1:0] LONG_TERM = W'(LONG_CYCLES - 1);
    localparam logic [W-1:0] GAP_TERM  = W'(GAP_CYCLES - 1);

    state_t state, next;
    logic [W-1:0] count;
    logic done, clr, en;
    logic short_d, long_d, double_d, held_d;

    // The timer only measures the hold window and the release gap; it restarts on every state change
    assign clr = state != next || state == IDLE;
    assign en  = (state == PRESS1 || state == WAIT_GAP) && count != '1;

    cycle_timer #(.W(W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .term  (state == WAIT_GAP ? GAP_TERM : LONG_TERM),
        .count (count),
        .done  (done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    // Next state: release beats the hold terminal count, a new press beats the gap terminal count
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = press_edge ? PRESS1 : IDLE;
            PRESS1:    next = !db_level ? WAIT_GAP : (done ? LONG_HELD : PRESS1);
            WAIT_GAP:  next = press_edge ? PRESS2 : (done ? IDLE : WAIT_GAP);
            PRESS2:    next = db_level ? PRESS2 : IDLE;
            LONG_HELD: next = db_level ? LONG_HELD : IDLE;
            default:   next = IDLE;
        endcase
    end

    // Event decode from the transition about to be taken; mutually exclusive by construction
    always_comb begin
        short_d  = state == WAIT_GAP && next == IDLE;
        long_d   = state == PRESS1 && next == LONG_HELD;
        double_d = state == WAIT_GAP && next == PRESS2;
        held_d   = next == LONG_HELD;
    end

    // Registered outputs; the event count advances together with the pulse it counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
            event_count  <= '0;
        end else begin
            short_press  <= short_d;
            long_press   <= long_d;
            double_press <= double_d;
            held         <= held_d;
            event_count  <= event_count + 8'(short_d | long_d | double_d);
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: random press trains checked against an arithmetic event model
module tb_press_classifier;

    localparam int L    = 20;
    localparam int G    = 10;
    localparam int MAXN = 16000;

    logic       clk = 1'b0;
    logic       reset, db_level, press_edge;
    logic       short_press, long_press, double_press, held;
    logic [7:0] event_count;

    int compared   = 0;
    int mismatched = 0;

    bit         lvl [MAXN+2];
    bit         pe_a[MAXN+2];
    bit         es  [MAXN+2];
    bit         el  [MAXN+2];
    bit         ed  [MAXN+2];
    bit         eh  [MAXN+2];
    logic [7:0] ec  [MAXN+2];
    int         ps[$];
    int         ph[$];

    press_classifier #(.LONG_CYCLES(L), .GAP_CYCLES(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .db_level     (db_level),
        .press_edge   (press_edge),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .held         (held),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_short"}, 32'(short_press), 0);
        check({tag, "_long"}, 32'(long_press), 0);
        check({tag, "_double"}, 32'(double_press), 0);
        check({tag, "_held"}, 32'(held), 0);
        check({tag, "_count"}, 32'(event_count), 0);
    endtask

    initial begin
        int s, h, g, k, i, st, hh, r;
        logic [7:0] c;
        int dh[8] = '{5, 30, 5, 5, 5, 5, 20, 21};
        int dg[8] = '{15, 5, 4, 15, 10, 12, 15, 15};

        // Press trains: directed boundary cases first, then random with boundary-weighted lengths
        s = 3;
        k = 0;
        while (1) begin
            if (k < 8) begin
                h = dh[k];
                g = dg[k];
            end else begin
                case ($urandom_range(0, 9))
                    0: h = L;
                    1: h = L + 1;
                    2: h = L - 1;
                    default: h = $urandom_range(1, 30);
                endcase
                case ($urandom_range(0, 9))
                    0: g = G;
                    1: g = G + 1;
                    2: g = 1;
                    default: g = $urandom_range(1, 20);
                endcase
            end
            if (s + h + g + G + 5 > MAXN) break;
            ps.push_back(s);
            ph.push_back(h);
            for (int n = s; n < s + h; n++) lvl[n] = 1'b1;
            s += h + g;
            k++;
        end
        for (int n = 1; n <= MAXN; n++) pe_a[n] = lvl[n] && !lvl[n-1];

        // Expected events: edge n means the n-th rising edge of the random phase
        i = 0;
        while (i < ps.size()) begin
            st = ps[i];
            hh = ph[i];
            if (hh > L) begin
                el[st+L] = 1'b1;
                for (int n = st + L; n < st + hh; n++) eh[n] = 1'b1;
                i++;
            end else begin
                r = st + hh;
                if (i + 1 < ps.size() && ps[i+1] - r <= G) begin
                    ed[ps[i+1]] = 1'b1;
                    i += 2;
                end else begin
                    es[r+G] = 1'b1;
                    i++;
                end
            end
        end
        c = 8'd0;
        for (int n = 0; n <= MAXN; n++) begin
            c += 8'(es[n] + el[n] + ed[n]);
            ec[n] = c;
        end

        // Reset state
        reset = 1'b1;
        db_level = 1'b0;
        press_edge = 1'b0;
        #1;
        check_quiet("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Long hold, then asynchronous reset while held
        @(negedge clk);
        db_level = 1'b1;
        press_edge = 1'b1;
        @(negedge clk);
        press_edge = 1'b0;
        repeat (24) @(negedge clk);
        check("pre_rst_held", 32'(held), 1);
        check("pre_rst_count", 32'(event_count), 1);
        #2 reset = 1'b1;
        #1;
        check_quiet("async_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check_quiet("post_rst");
        end
        db_level = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("post_rst_rel");

        // Random phase: drive for edge n, sample on the following falling edge
        for (int n = 1; n <= MAXN; n++) begin
            db_level = lvl[n];
            press_edge = pe_a[n];
            @(posedge clk);
            @(negedge clk);
            check("short", 32'(short_press), 32'(es[n]));
            check("long", 32'(long_press), 32'(el[n]));
            check("double", 32'(double_press), 32'(ed[n]));
            check("held", 32'(held), 32'(eh[n]));
            check("count", 32'(event_count), 32'(ec[n]));
            check("onehot", 32'(short_press + long_press + double_press <= 2'd1), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
